// File: rtl/conv_loop_scheduler_pkg.sv
// Shared types for the convolution loop scheduler: FSM states, stride
// modes and the stride-mode to shift mapping.
package conv_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    STRIDE_1    = 2'd0,
    STRIDE_2    = 2'd1,
    STRIDE_4    = 2'd2,
    STRIDE_RSVD = 2'd3
  } stride_mode_e;

  // log2 of the spatial step; the reserved mode behaves as step 1
  function automatic logic [1:0] stride_shift(input stride_mode_e mode);
    logic [1:0] sh;
    sh = 2'd0;
    case (mode)
      STRIDE_2: sh = 2'd1;
      STRIDE_4: sh = 2'd2;
      default:  sh = 2'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/conv_loop_scheduler_wrap_counter.sv
// One loop level: adds step on enable and wraps to zero once the next
// value would reach limit. wrap is combinational so levels chain in one cycle.
module wrap_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [2:0]       step_i,
  input  logic [WIDTH:0]   limit_i,
  output logic [WIDTH-1:0] value_o,
  output logic             wrap_o
);

  localparam int unsigned SW = WIDTH + 3;

  logic [WIDTH-1:0] value_q, value_d;
  logic [SW-1:0]    sum;

  assign sum     = SW'(value_q) + SW'(step_i);
  assign wrap_o  = enable_i && (sum >= SW'(limit_i));
  assign value_o = value_q;

  // next value: advance or wrap only when enabled
  always_comb begin
    value_d = value_q;
    if (enable_i) begin
      value_d = wrap_o ? '0 : sum[WIDTH-1:0];
    end
  end

  // counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/conv_loop_scheduler.sv
// Convolution loop scheduler: walks y, x, co, ci, ky, kx (outer to inner)
// under a valid/ready handshake and flags accumulator first/last terms.
module conv_loop_scheduler
  import conv_sched_pkg::*;
#(
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned INPUT_NB_CHANNELS  = 64,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned KERNEL_SIZE        = 3,
  localparam int unsigned XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int unsigned YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int unsigned KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1,
  localparam int unsigned CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
  localparam int unsigned COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
  input  logic           clk,
  input  logic           rst_in,
  input  logic           start,
  input  logic [1:0]     conv_stride_mode,
  output logic           running,
  output logic           done,
  output logic           step_valid,
  input  logic           step_ready,
  output logic [XW-1:0]  x,
  output logic [YW-1:0]  y,
  output logic [KW-1:0]  kx,
  output logic [KW-1:0]  ky,
  output logic [CIW-1:0] ci,
  output logic [COW-1:0] co,
  output logic           first_acc,
  output logic           last_acc,
  output logic [XW-1:0]  out_x,
  output logic [YW-1:0]  out_y
);

  localparam logic [XW:0]    X_LIM   = (XW+1)'(FEATURE_MAP_WIDTH);
  localparam logic [YW:0]    Y_LIM   = (YW+1)'(FEATURE_MAP_HEIGHT);
  localparam logic [KW:0]    K_LIM   = (KW+1)'(KERNEL_SIZE);
  localparam logic [CIW:0]   CI_LIM  = (CIW+1)'(INPUT_NB_CHANNELS);
  localparam logic [COW:0]   CO_LIM  = (COW+1)'(OUTPUT_NB_CHANNELS);
  localparam logic [KW-1:0]  K_LAST  = KW'(KERNEL_SIZE - 1);
  localparam logic [CIW-1:0] CI_LAST = CIW'(INPUT_NB_CHANNELS - 1);

  state_e       state_q, state_d;
  stride_mode_e stride_q, stride_d;

  logic       hs;
  logic [1:0] shift;
  logic [2:0] xy_step;
  logic       kx_wrap, ky_wrap, ci_wrap, co_wrap, x_wrap, y_wrap;

  assign hs      = step_valid & step_ready;
  assign shift   = stride_shift(stride_q);
  assign xy_step = 3'd1 << shift;

  // Each level is enabled by the wrap of the level inside it; the outermost
  // wrap therefore marks the handshake on the final index of the pass.
  wrap_counter #(.WIDTH(KW)) u_kx (
    .clk(clk), .rst_i(rst_in), .enable_i(hs), .step_i(3'd1),
    .limit_i(K_LIM), .value_o(kx), .wrap_o(kx_wrap)
  );
  wrap_counter #(.WIDTH(KW)) u_ky (
    .clk(clk), .rst_i(rst_in), .enable_i(kx_wrap), .step_i(3'd1),
    .limit_i(K_LIM), .value_o(ky), .wrap_o(ky_wrap)
  );
  wrap_counter #(.WIDTH(CIW)) u_ci (
    .clk(clk), .rst_i(rst_in), .enable_i(ky_wrap), .step_i(3'd1),
    .limit_i(CI_LIM), .value_o(ci), .wrap_o(ci_wrap)
  );
  wrap_counter #(.WIDTH(COW)) u_co (
    .clk(clk), .rst_i(rst_in), .enable_i(ci_wrap), .step_i(3'd1),
    .limit_i(CO_LIM), .value_o(co), .wrap_o(co_wrap)
  );
  wrap_counter #(.WIDTH(XW)) u_x (
    .clk(clk), .rst_i(rst_in), .enable_i(co_wrap), .step_i(xy_step),
    .limit_i(X_LIM), .value_o(x), .wrap_o(x_wrap)
  );
  wrap_counter #(.WIDTH(YW)) u_y (
    .clk(clk), .rst_i(rst_in), .enable_i(x_wrap), .step_i(xy_step),
    .limit_i(Y_LIM), .value_o(y), .wrap_o(y_wrap)
  );

  // next-state, stride latch and status outputs
  always_comb begin
    state_d    = state_q;
    stride_d   = stride_q;
    running    = 1'b0;
    done       = 1'b0;
    step_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          stride_d = stride_mode_e'(conv_stride_mode);
        end
      end
      RUN: begin
        running    = 1'b1;
        step_valid = 1'b1;
        if (y_wrap) begin
          state_d = DONE;
        end
      end
      DONE: begin
        running = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and latched stride registers; reset overrides a coincident start
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q  <= IDLE;
      stride_q <= STRIDE_1;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
    end
  end

  assign first_acc = (ci == '0) && (ky == '0) && (kx == '0);
  assign last_acc  = (ci == CI_LAST) && (ky == K_LAST) && (kx == K_LAST);
  assign out_x     = x >> shift;
  assign out_y     = y >> shift;

endmodule
